// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: opcodes, status codes, FSM states and length/format helpers.
package y86_pkg;

  localparam int unsigned IMEM_BYTES = 10;
  localparam int unsigned IMEM_W     = IMEM_BYTES * 8;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  // INS is the 2-bit wrap of code 4
  localparam logic [1:0] STAT_INS = 2'd0;
  localparam logic [1:0] STAT_AOK = 2'd1;
  localparam logic [1:0] STAT_HLT = 2'd2;
  localparam logic [1:0] STAT_ADR = 2'd3;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_OUT  = 3'd2,
    S_PC   = 3'd3,
    S_HALT = 3'd4
  } fetch_state_e;

  // Instruction length in bytes; illegal opcodes report 1 (caller overrides valP)
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      I_HALT, I_NOP, I_RET:                 instr_len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:     instr_len = 4'd2;
      I_JXX, I_CALL:                        instr_len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         instr_len = 4'd10;
      default:                              instr_len = 4'd1;
    endcase
  endfunction

  // True when byte1 carries the rA/rB register specifier
  function automatic logic instr_has_reg(input logic [3:0] ic);
    case (ic)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ:               instr_has_reg = 1'b1;
      default:                              instr_has_reg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_split.sv
// Combinational split of a 10-byte instruction window into Y86-64 fields.
module instr_split
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [IMEM_W-1:0] imem_rdata,
  input  logic [ADDR_W-1:0] pc,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [ADDR_W-1:0] valC,
  output logic [ADDR_W-1:0] valP,
  output logic              need_reg,
  output logic              ins_err
);

  // Field extraction; rA/rB are raw byte1 nibbles, qualified by need_reg upstream
  always_comb begin
    icode    = imem_rdata[7:4];
    ifun     = imem_rdata[3:0];
    rA       = imem_rdata[15:12];
    rB       = imem_rdata[11:8];
    need_reg = instr_has_reg(icode);
    ins_err  = (icode > I_POPQ);
    case (icode)
      I_JXX, I_CALL:                valC = ADDR_W'(imem_rdata[71:8]);
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: valC = ADDR_W'(imem_rdata[79:16]);
      default:                      valC = '0;
    endcase
    valP = pc + ADDR_W'(instr_len(icode));
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 SEQ fetch stage: owns the PC, reads imem, registers decoded fields, hands off downstream.
module fetch_stage
  import y86_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] START_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [IMEM_W-1:0] imem_rdata,
  input  logic              imem_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [ADDR_W-1:0] valC,
  output logic [ADDR_W-1:0] valP,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        stat,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] new_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              imem_req_q, imem_req_d;
  logic              out_valid_q, out_valid_d;
  logic [3:0]        icode_q, icode_d, ifun_q, ifun_d;
  logic [3:0]        ra_q, ra_d, rb_q, rb_d;
  logic [ADDR_W-1:0] valc_q, valc_d, valp_q, valp_d;
  logic [1:0]        stat_q, stat_d;

  logic [3:0]        sp_icode, sp_ifun, sp_ra, sp_rb;
  logic [ADDR_W-1:0] sp_valc, sp_valp;
  logic              sp_need_reg, sp_ins_err;

  logic accept, pc_take, ack_take, fetch_ok;

  instr_split #(.ADDR_W(ADDR_W)) u_split (
    .imem_rdata (imem_rdata),
    .pc         (pc_q),
    .icode      (sp_icode),
    .ifun       (sp_ifun),
    .rA         (sp_ra),
    .rB         (sp_rb),
    .valC       (sp_valc),
    .valP       (sp_valp),
    .need_reg   (sp_need_reg),
    .ins_err    (sp_ins_err)
  );

  assign accept   = (state_q == S_OUT) && out_ready;
  assign pc_take  = pc_load && ((state_q == S_PC) || (accept && (stat_q == STAT_AOK)));
  assign ack_take = (state_q == S_WAIT) && imem_ack;
  assign fetch_ok = !imem_err && !sp_ins_err;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_REQ;
    else        state_q <= state_d;
  end

  // Next-state; S_REQ leaves only after its request cycle has actually been driven
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:  if (imem_req_q) state_d = S_WAIT;
      S_WAIT: if (imem_ack)   state_d = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          if (stat_q != STAT_AOK) state_d = S_HALT;
          else if (pc_load)       state_d = S_REQ;
          else                    state_d = S_PC;
        end
      end
      S_PC:   if (pc_load) state_d = S_REQ;
      S_HALT: state_d = S_HALT;
      default: state_d = S_REQ;
    endcase
  end

  // Output/datapath next values: handshake flags follow the next state, fields load on ack
  always_comb begin
    imem_req_d  = (state_d == S_REQ);
    out_valid_d = (state_d == S_OUT);
    pc_d        = pc_q;
    icode_d     = icode_q;
    ifun_d      = ifun_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    valc_d      = valc_q;
    valp_d      = valp_q;
    stat_d      = stat_q;

    if (pc_take) pc_d = new_pc;

    if (ack_take) begin
      icode_d = sp_icode;
      ifun_d  = sp_ifun;
      ra_d    = sp_need_reg ? sp_ra : REG_NONE;
      rb_d    = sp_need_reg ? sp_rb : REG_NONE;
      valc_d  = fetch_ok ? sp_valc : '0;
      valp_d  = fetch_ok ? sp_valp : pc_q;
      if (imem_err)              stat_d = STAT_ADR;
      else if (sp_ins_err)       stat_d = STAT_INS;
      else if (sp_icode == I_HALT) stat_d = STAT_HLT;
      else                       stat_d = STAT_AOK;
    end
  end

  // PC, handshake and decoded-field registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= START_PC;
      imem_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      icode_q     <= 4'h0;
      ifun_q      <= 4'h0;
      ra_q        <= REG_NONE;
      rb_q        <= REG_NONE;
      valc_q      <= '0;
      valp_q      <= '0;
      stat_q      <= STAT_AOK;
    end else begin
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      out_valid_q <= out_valid_d;
      icode_q     <= icode_d;
      ifun_q      <= ifun_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      valc_q      <= valc_d;
      valp_q      <= valp_d;
      stat_q      <= stat_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign rA        = ra_q;
  assign rB        = rb_q;
  assign valC      = valc_q;
  assign valP      = valp_q;
  assign pc        = pc_q;
  assign stat      = stat_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random instruction stream against a byte-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, imem_err;
  logic [63:0] imem_addr;
  logic [79:0] imem_rdata;
  logic        out_valid, out_ready, pc_load;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc, new_pc;
  logic [1:0]  stat;

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] model_pc;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [1:0]  stat;
  } exp_t;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(64), .START_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .pc(pc), .stat(stat),
    .pc_load(pc_load), .new_pc(new_pc)
  );

  // Reference: byte array view, length table, little-endian constant assembly
  function automatic exp_t model(input logic [79:0] raw, input logic [63:0] at_pc, input logic err);
    exp_t e;
    logic [7:0] b [10];
    int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};
    int reg_tab [16] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    int c_off;
    for (int i = 0; i < 10; i++) b[i] = raw[8*i +: 8];
    e.icode = b[0][7:4];
    e.ifun  = b[0][3:0];
    e.ra    = (reg_tab[e.icode] != 0) ? b[1][7:4] : 4'hF;
    e.rb    = (reg_tab[e.icode] != 0) ? b[1][3:0] : 4'hF;
    c_off   = (len_tab[e.icode] == 9) ? 1 : (len_tab[e.icode] == 10) ? 2 : 0;
    e.valc  = 64'h0;
    if (c_off != 0)
      for (int k = 0; k < 8; k++) e.valc = e.valc + (64'(b[c_off + k]) << (8 * k));
    e.valp  = at_pc + 64'(len_tab[e.icode]);
    if (err)                  e.stat = 2'd3;
    else if (e.icode > 4'hB)  e.stat = 2'd0;
    else if (e.icode == 4'h0) e.stat = 2'd2;
    else                      e.stat = 2'd1;
    if (e.stat == 2'd3 || e.stat == 2'd0) begin
      e.valp = at_pc;
      e.valc = 64'h0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset();
    check("rst_req",   64'(imem_req), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_icode", 64'(icode), 64'h0);
    check("rst_ifun",  64'(ifun), 64'h0);
    check("rst_ra",    64'(rA), 64'hF);
    check("rst_rb",    64'(rB), 64'hF);
    check("rst_valc",  valC, 64'h0);
    check("rst_valp",  valP, 64'h0);
    check("rst_stat",  64'(stat), 64'h1);
    check("rst_pc",    pc, 64'h0);
  endtask

  task automatic check_outputs(input exp_t e);
    check("out_valid", 64'(out_valid), 64'h1);
    check("icode", 64'(icode), 64'(e.icode));
    check("ifun",  64'(ifun),  64'(e.ifun));
    check("rA",    64'(rA),    64'(e.ra));
    check("rB",    64'(rB),    64'(e.rb));
    check("valC",  valC, e.valc);
    check("valP",  valP, e.valp);
    check("stat",  64'(stat), 64'(e.stat));
    check("pc",    pc, model_pc);
  endtask

  // Wait (bounded) for a request, answer it after ack_dly extra cycles, check the decode
  task automatic do_fetch(input logic [79:0] raw, input logic err, input int ack_dly, output exp_t e);
    bit found = 1'b0;
    e = '0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("req_seen", 64'(found), 64'h1);
    if (found) begin
      check("imem_addr", imem_addr, model_pc);
      @(negedge clk);
      check("req_one_cycle", 64'(imem_req), 64'h0);
      repeat (ack_dly) @(negedge clk);
      check("valid_before_ack", 64'(out_valid), 64'h0);
      imem_ack = 1'b1; imem_rdata = raw; imem_err = err;
      @(negedge clk);
      imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = {$urandom, $urandom, 16'($urandom)};
      e = model(raw, model_pc, err);
      check_outputs(e);
    end
  endtask

  task automatic accept(input logic with_load, input logic [63:0] np, input logic [1:0] cur_stat);
    out_ready = 1'b1; pc_load = with_load; new_pc = np;
    @(negedge clk);
    out_ready = 1'b0; pc_load = 1'b0;
    check("valid_after_accept", 64'(out_valid), 64'h0);
    if (with_load && cur_stat == 2'd1) begin
      model_pc = np;
      check("req_after_accept_load", 64'(imem_req), 64'h1);
      check("addr_after_accept_load", imem_addr, np);
    end else begin
      check("req_after_accept", 64'(imem_req), 64'h0);
    end
  endtask

  task automatic load_pc(input logic [63:0] np);
    pc_load = 1'b1; new_pc = np;
    @(negedge clk);
    pc_load = 1'b0;
    model_pc = np;
    check("req_after_load", 64'(imem_req), 64'h1);
    check("addr_after_load", imem_addr, np);
  endtask

  initial begin
    exp_t e;
    logic [79:0] raw;
    logic [63:0] np;
    logic [79:0] irmov = {56'h0, 8'h0A, 8'hF2, 8'h30};
    logic [79:0] jmp   = {64'h0, 8'h20, 8'h70};

    rst_n = 1'b0; imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = '0;
    out_ready = 1'b0; pc_load = 1'b0; new_pc = '0; model_pc = 64'h0;
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    @(negedge clk);

    // irmovq $10,%rdx at 0
    do_fetch(irmov, 1'b0, 0, e);
    check("t1_valC", valC, 64'd10);
    check("t1_valP", valP, 64'd10);
    accept(1'b0, 64'h0, e.stat);
    check("t1_idle_pc", pc, 64'h0);
    load_pc(64'd10);

    // jmp 0x20 at 10
    do_fetch(jmp, 1'b0, 0, e);
    check("t2_valC", valC, 64'h20);
    check("t2_valP", valP, 64'd19);

    // Stall: outputs stable, pc_load ignored
    for (int c = 0; c < 5; c++) begin
      pc_load = (c == 2); new_pc = 64'h999;
      @(negedge clk);
      pc_load = 1'b0;
      check("stall_valid", 64'(out_valid), 64'h1);
      check("stall_valC", valC, 64'h20);
      check("stall_icode", 64'(icode), 64'h7);
      check("stall_pc", pc, 64'd10);
    end
    accept(1'b0, 64'h0, e.stat);
    check("stall_pc_after", pc, 64'd10);
    load_pc(64'h1000);

    // Random legal instruction stream
    for (int k = 0; k < 30; k++) begin
      raw = {$urandom, $urandom, 16'($urandom)};
      raw[7:4] = 4'($urandom_range(1, 11));
      do_fetch(raw, 1'b0, int'($urandom_range(0, 2)), e);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      np = {$urandom, $urandom};
      if (k % 5 == 0) np = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 8));
      if ($urandom_range(0, 1) == 1) begin
        accept(1'b1, np, e.stat);
      end else begin
        accept(1'b0, np, e.stat);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        load_pc(np);
      end
    end

    // PC wrap on a nop at the top of memory
    do_fetch({72'h0, 8'h10}, 1'b0, 0, e);
    accept(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, e.stat);
    do_fetch({72'h0, 8'h10}, 1'b0, 0, e);
    check("wrap_valP", valP, 64'h0);
    accept(1'b1, 64'h100, e.stat);

    // Illegal opcode -> INS, then terminal halt
    do_fetch({72'h0, 8'hC0}, 1'b0, 0, e);
    check("ins_stat", 64'(stat), 64'h0);
    check("ins_valP", valP, 64'h100);
    accept(1'b0, 64'h0, e.stat);
    for (int c = 0; c < 6; c++) begin
      pc_load = (c == 1); new_pc = 64'h40;
      @(negedge clk);
      pc_load = 1'b0;
      check("halt_quiet", {62'h0, imem_req, out_valid}, 64'h0);
      check("halt_pc", pc, 64'h100);
    end

    // Reset out of halt, then address error
    rst_n = 1'b0; #1; check_reset();
    @(negedge clk); rst_n = 1'b1; model_pc = 64'h0;
    @(negedge clk);
    do_fetch(irmov, 1'b1, 1, e);
    check("adr_stat", 64'(stat), 64'h3);
    check("adr_valP", valP, 64'h0);
    check("adr_valC", valC, 64'h0);
    accept(1'b0, 64'h0, e.stat);
    repeat (3) @(negedge clk);
    check("adr_halt_req", 64'(imem_req), 64'h0);

    // Reset while waiting for imem; stale ack afterwards ignored
    rst_n = 1'b0; #1; rst_n = 1'b1; model_pc = 64'h0;
    @(negedge clk);
    do_fetch(irmov, 1'b0, 0, e);
    accept(1'b0, 64'h0, e.stat);
    load_pc(64'h40);
    @(negedge clk);
    check("mid_wait_req", 64'(imem_req), 64'h0);
    rst_n = 1'b0; #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1; model_pc = 64'h0;
    imem_ack = 1'b1; imem_rdata = jmp;
    @(negedge clk);
    imem_ack = 1'b0;
    check("stale_ack_valid", 64'(out_valid), 64'h0);
    do_fetch(irmov, 1'b0, 0, e);
    check("refetch_icode", 64'(icode), 64'h3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
